// File: rtl/game_period.sv
// ---------------------------------------------------------------------------
// game_period
//
// Game-period stage of the reaction game. A gameSig pulse from the prelim
// countdown starts a round: a target symbol is shown, then a level-dependent
// number of pseudo-random symbols is streamed on the 1 Hz tick. The player
// enters how often the target appeared and presses submit; the answer is
// scored, the level updated, and prelimSig requests the next prelim period.
//
// Ports:
//   Clk100M      in   system clock, all state on its rising edge
//   Rst_n        in   asynchronous active-low reset
//   Clk1Hz       in   slow clock, synchronised and edge-detected as data
//   gameSig      in   round start pulse (honoured in IDLE only)
//   guess[5:0]   in   player's count of target occurrences
//   submitBtn    in   answer button (level), edge-detected internally
//   prelimSig    out  one-cycle request for the next prelim period
//   curLevel     out  current level 0..15
//   roundWin     out  one-cycle pulse on a correct answer
//   roundLose    out  one-cycle pulse on a wrong answer or timeout
//   gameSeg0..3  out  active-low segments, bit0=a .. bit6=g, bit7=dp
//   dbgTarget    out  latched target symbol code
//   dbgCount     out  running count of target occurrences
//
// Build option: define GAME_PERIOD_REVEAL_EN to show the true count instead
// of the player's guess on gameSeg1/gameSeg0 while the result is displayed.
// ---------------------------------------------------------------------------
module game_period #(
    parameter int SYM_BASE      = 4,
    parameter int SYM_PER_LEVEL = 2,
    parameter int TARGET_TICKS  = 2,
    parameter int ANS_TIMEOUT   = 10,
    parameter int RESULT_TICKS  = 2
) (
    input  logic       Clk100M,
    input  logic       Rst_n,
    input  logic       Clk1Hz,
    input  logic       gameSig,
    input  logic [5:0] guess,
    input  logic       submitBtn,
    output logic       prelimSig,
    output logic [3:0] curLevel,
    output logic       roundWin,
    output logic       roundLose,
    output logic [7:0] gameSeg0,
    output logic [7:0] gameSeg1,
    output logic [7:0] gameSeg2,
    output logic [7:0] gameSeg3,
    output logic [1:0] dbgTarget,
    output logic [5:0] dbgCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW_TARGET,
        S_STREAM,
        S_ANSWER,
        S_RESULT
    } state_t;

    state_t      state_q,     state_d;
    logic [15:0] lfsr_q,      lfsr_d;
    logic [2:0]  tick_sync_q, tick_sync_d;
    logic [2:0]  btn_sync_q,  btn_sync_d;
    logic [3:0]  level_q,     level_d;
    logic [1:0]  target_q,    target_d;
    logic [1:0]  sym_q,       sym_d;
    logic [5:0]  count_q,     count_d;
    logic [5:0]  sym_cnt_q,   sym_cnt_d;
    logic [7:0]  tick_cnt_q,  tick_cnt_d;
    logic        win_q,       win_d;
    logic        prelim_q,    prelim_d;
    logic        win_pls_q,   win_pls_d;
    logic        lose_pls_q,  lose_pls_d;

    logic        tick;
    logic        sub_edge;
    logic [5:0]  num_sym;

    // Stage 0/1 synchronise, stage 2 holds the previous synchronised value.
    assign tick     = tick_sync_q[1] & ~tick_sync_q[2];
    assign sub_edge = btn_sync_q[1]  & ~btn_sync_q[2];
    assign num_sym  = 6'(SYM_BASE + SYM_PER_LEVEL * int'(level_q));

    function automatic logic [7:0] sym_pat(input logic [1:0] s);
        case (s)
            2'd0:    sym_pat = 8'hFE;
            2'd1:    sym_pat = 8'hBF;
            2'd2:    sym_pat = 8'hF7;
            default: sym_pat = 8'h7F;
        endcase
    endfunction

    function automatic logic [7:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;
            4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;
            4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;
            4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;
            4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
        endcase
    endfunction

    // State register
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= 16'hACE1;
            tick_sync_q <= '0;
            btn_sync_q  <= '0;
            level_q     <= '0;
            target_q    <= '0;
            sym_q       <= '0;
            count_q     <= '0;
            sym_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            win_q       <= 1'b0;
            prelim_q    <= 1'b0;
            win_pls_q   <= 1'b0;
            lose_pls_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            tick_sync_q <= tick_sync_d;
            btn_sync_q  <= btn_sync_d;
            level_q     <= level_d;
            target_q    <= target_d;
            sym_q       <= sym_d;
            count_q     <= count_d;
            sym_cnt_q   <= sym_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            win_q       <= win_d;
            prelim_q    <= prelim_d;
            win_pls_q   <= win_pls_d;
            lose_pls_q  <= lose_pls_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        tick_sync_d = {tick_sync_q[1:0], Clk1Hz};
        btn_sync_d  = {btn_sync_q[1:0], submitBtn};
        level_d     = level_q;
        target_d    = target_q;
        sym_d       = sym_q;
        count_d     = count_q;
        sym_cnt_d   = sym_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        win_d       = win_q;
        prelim_d    = 1'b0;
        win_pls_d   = 1'b0;
        lose_pls_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (gameSig) begin
                    target_d   = lfsr_q[3:2];
                    count_d    = '0;
                    sym_cnt_d  = '0;
                    tick_cnt_d = '0;
                    state_d    = S_SHOW_TARGET;
                end
            end
            S_SHOW_TARGET: begin
                if (tick) begin
                    if (tick_cnt_q == 8'(TARGET_TICKS - 1)) begin
                        tick_cnt_d = '0;
                        state_d    = S_STREAM;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 8'd1;
                    end
                end
            end
            S_STREAM: begin
                // The tick after the last symbol leaves STREAM, so that
                // symbol stays on the display for a whole tick.
                if (tick) begin
                    if (sym_cnt_q == num_sym) begin
                        tick_cnt_d = '0;
                        state_d    = S_ANSWER;
                    end else begin
                        sym_d     = lfsr_q[1:0];
                        sym_cnt_d = sym_cnt_q + 6'd1;
                        if (lfsr_q[1:0] == target_q && count_q != 6'd63)
                            count_d = count_q + 6'd1;
                    end
                end
            end
            S_ANSWER: begin
                // Submit is checked first so it wins over a coincident timeout.
                if (sub_edge) begin
                    tick_cnt_d = '0;
                    state_d    = S_RESULT;
                    if (guess == count_q) begin
                        win_d     = 1'b1;
                        win_pls_d = 1'b1;
                        if (level_q != 4'd15)
                            level_d = level_q + 4'd1;
                    end else begin
                        win_d      = 1'b0;
                        lose_pls_d = 1'b1;
                    end
                end else if (tick) begin
                    if (tick_cnt_q == 8'(ANS_TIMEOUT - 1)) begin
                        tick_cnt_d = '0;
                        win_d      = 1'b0;
                        lose_pls_d = 1'b1;
                        state_d    = S_RESULT;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 8'd1;
                    end
                end
            end
            S_RESULT: begin
                if (tick) begin
                    if (tick_cnt_q == 8'(RESULT_TICKS - 1)) begin
                        tick_cnt_d = '0;
                        prelim_d   = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        gameSeg0 = 8'hFF;
        gameSeg1 = 8'hFF;
        gameSeg2 = 8'hFF;
        gameSeg3 = 8'hFF;
        case (state_q)
            S_SHOW_TARGET: gameSeg3 = sym_pat(target_q);
            S_STREAM: begin
                // Blank until the first symbol has been drawn.
                if (sym_cnt_q != 6'd0)
                    gameSeg3 = sym_pat(sym_q);
            end
            S_ANSWER: begin
                gameSeg3 = 8'hBF;
                gameSeg1 = hex7({2'b00, guess[5:4]});
                gameSeg0 = hex7(guess[3:0]);
            end
            S_RESULT: begin
                gameSeg3 = win_q ? 8'h8C : 8'h8E;
`ifdef GAME_PERIOD_REVEAL_EN
                gameSeg1 = hex7({2'b00, count_q[5:4]});
                gameSeg0 = hex7(count_q[3:0]);
`else
                gameSeg1 = hex7({2'b00, guess[5:4]});
                gameSeg0 = hex7(guess[3:0]);
`endif
            end
            default: ;
        endcase
    end

    assign prelimSig = prelim_q;
    assign curLevel  = level_q;
    assign roundWin  = win_pls_q;
    assign roundLose = lose_pls_q;
    assign dbgTarget = target_q;
    assign dbgCount  = count_q;

endmodule

// File: tb/tb_game_period.sv
// ---------------------------------------------------------------------------
// tb_game_period
//
// Self-checking bench for game_period. The reference model plays each round
// at the level of game rules: a table of LFSR values indexed by the number of
// clock cycles since reset gives the symbol drawn on each tick, the expected
// count, outcome, level and display contents follow from those rules.
// ---------------------------------------------------------------------------
module tb_game_period;

    localparam int TAB_SIZE = 60000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_1hz = 1'b0;
    logic       game_sig = 1'b0;
    logic [5:0] guess = '0;
    logic       submit_btn = 1'b0;
    logic       prelim_sig;
    logic [3:0] cur_level;
    logic       round_win;
    logic       round_lose;
    logic [7:0] seg0, seg1, seg2, seg3;
    logic [1:0] dbg_target;
    logic [5:0] dbg_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int level_m = 0;
    logic [15:0] lfsr_tab [0:TAB_SIZE-1];

    game_period dut (
        .Clk100M   (clk),
        .Rst_n     (rst_n),
        .Clk1Hz    (clk_1hz),
        .gameSig   (game_sig),
        .guess     (guess),
        .submitBtn (submit_btn),
        .prelimSig (prelim_sig),
        .curLevel  (cur_level),
        .roundWin  (round_win),
        .roundLose (round_lose),
        .gameSeg0  (seg0),
        .gameSeg1  (seg1),
        .gameSeg2  (seg2),
        .gameSeg3  (seg3),
        .dbgTarget (dbg_target),
        .dbgCount  (dbg_count)
    );

    always #5 clk = ~clk;

    // Cycles elapsed since reset release; indexes the LFSR table.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [7:0] sym_pat(input logic [1:0] s);
        case (s)
            2'd0:    sym_pat = 8'hFE;
            2'd1:    sym_pat = 8'hBF;
            2'd2:    sym_pat = 8'hF7;
            default: sym_pat = 8'h7F;
        endcase
    endfunction

    function automatic logic [7:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;
            4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;
            4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;
            4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;
            4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Raise Clk1Hz and/or submitBtn after a settled low period; returns the
    // cycle index whose LFSR value the resulting edge consumes, and leaves
    // time at 1 ns after that consuming clock edge.
    task automatic pulse_inputs(input bit t, input bit s, output int c_used);
        @(negedge clk);
        clk_1hz    = 1'b0;
        submit_btn = 1'b0;
        repeat (3) @(negedge clk);
        clk_1hz    = t;
        submit_btn = s;
        @(negedge clk);
        @(negedge clk);
        c_used = cyc;
        if (c_used >= TAB_SIZE) begin
            $display("FAIL lfsr_tab: index %0d out of range", c_used);
            $fatal(1, "table overflow");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic game_pulse(output int c_used);
        @(negedge clk);
        game_sig = 1'b1;
        c_used = cyc;
        @(posedge clk);
        #1;
        game_sig = 1'b0;
    endtask

    // mode 0: submit right away; 1: let it time out; 2: submit on the timeout tick
    task automatic play_round(input int mode, input int delta, input bit gs_mid);
        int c, cnt, n;
        logic [15:0] v;
        logic [1:0] tgt, sym;
        logic [5:0] g, shown;
        bit exp_win;
        cnt = 0;
        game_pulse(c);
        v = lfsr_tab[c];
        tgt = v[3:2];
        chk("start_target", dbg_target, tgt);
        chk("start_count", dbg_count, 0);
        chk("show_seg3", seg3, sym_pat(tgt));
        pulse_inputs(1, 0, c);
        chk("show_seg3_t1", seg3, sym_pat(tgt));
        pulse_inputs(1, 0, c);
        n = 4 + 2 * level_m;
        for (int i = 0; i < n; i++) begin
            pulse_inputs(1, 0, c);
            v = lfsr_tab[c];
            sym = v[1:0];
            if (sym == tgt && cnt < 63) cnt++;
            chk("stream_seg3", seg3, sym_pat(sym));
            chk("stream_count", dbg_count, cnt);
            chk("stream_seg0", seg0, 8'hFF);
            if (gs_mid && i == 1) begin
                game_pulse(c);
                chk("gs_ignored_target", dbg_target, tgt);
                chk("gs_ignored_count", dbg_count, cnt);
                chk("gs_ignored_seg3", seg3, sym_pat(sym));
            end
        end
        g = 6'(cnt + delta);
        guess = g;
        pulse_inputs(1, 0, c);
        chk("answer_seg3", seg3, 8'hBF);
        chk("answer_seg2", seg2, 8'hFF);
        chk("answer_seg1", seg1, hex7({2'b00, g[5:4]}));
        chk("answer_seg0", seg0, hex7(g[3:0]));
        exp_win = (int'(g) == cnt);
        if (mode == 0) begin
            pulse_inputs(0, 1, c);
        end else begin
            for (int k = 0; k < 9; k++) begin
                pulse_inputs(1, 0, c);
                chk("wait_no_lose", round_lose, 1'b0);
                chk("wait_seg3", seg3, 8'hBF);
            end
            if (mode == 1) begin
                pulse_inputs(1, 0, c);
                exp_win = 1'b0;
            end else begin
                pulse_inputs(1, 1, c);
            end
        end
        if (exp_win && level_m < 15) level_m++;
        chk("round_win", round_win, exp_win);
        chk("round_lose", round_lose, !exp_win);
        chk("cur_level", cur_level, level_m);
        chk("result_seg3", seg3, exp_win ? 8'h8C : 8'h8E);
`ifdef GAME_PERIOD_REVEAL_EN
        shown = 6'(cnt);
`else
        shown = g;
`endif
        chk("result_seg1", seg1, hex7({2'b00, shown[5:4]}));
        chk("result_seg0", seg0, hex7(shown[3:0]));
        @(posedge clk);
        #1;
        chk("win_one_cycle", round_win, 1'b0);
        chk("lose_one_cycle", round_lose, 1'b0);
        pulse_inputs(1, 0, c);
        chk("prelim_early", prelim_sig, 1'b0);
        chk("result_hold_seg3", seg3, exp_win ? 8'h8C : 8'h8E);
        pulse_inputs(1, 0, c);
        chk("prelim_pulse", prelim_sig, 1'b1);
        chk("idle_seg3", seg3, 8'hFF);
        chk("idle_seg0", seg0, 8'hFF);
        @(posedge clk);
        #1;
        chk("prelim_one_cycle", prelim_sig, 1'b0);
        $display("round mode=%0d syms=%0d target=%0d count=%0d guess=%0d win=%0d level=%0d",
                 mode, n, tgt, cnt, g, exp_win, level_m);
    endtask

    initial begin
        int c;
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < TAB_SIZE; i++) begin
            lfsr_tab[i] = s;
            s = lfsr_step(s);
        end

        repeat (3) @(negedge clk);
        #1;
        chk("rst_seg0", seg0, 8'hFF);
        chk("rst_seg1", seg1, 8'hFF);
        chk("rst_seg2", seg2, 8'hFF);
        chk("rst_seg3", seg3, 8'hFF);
        chk("rst_level", cur_level, 0);
        chk("rst_pulses", {prelim_sig, round_win, round_lose}, 0);
        chk("rst_dbg", {dbg_target, dbg_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort a round mid-stream with reset.
        game_pulse(c);
        repeat (4) pulse_inputs(1, 0, c);
        @(negedge clk);
        clk_1hz = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("midrst_seg3", seg3, 8'hFF);
        chk("midrst_seg0", seg0, 8'hFF);
        chk("midrst_level", cur_level, 0);
        chk("midrst_pulses", {prelim_sig, round_win, round_lose}, 0);
        chk("midrst_count", dbg_count, 0);
        $display("reset asserted mid-stream");
        level_m = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        play_round(0, 0, 1'b0);   // correct answer at level 0
        play_round(0, 1, 1'b0);   // wrong answer
        play_round(1, 0, 1'b0);   // timeout
        play_round(2, 0, 1'b0);   // submit on the timeout tick, correct
        play_round(0, 0, 1'b1);   // gameSig mid-stream ignored

        while (level_m < 15) begin
            if ($urandom_range(0, 3) == 0)
                play_round(0, int'($urandom_range(1, 63)), 1'b0);
            else
                play_round(0, 0, 1'b0);
        end
        play_round(0, 0, 1'b0);   // win at top level keeps 15, 34 symbols
        play_round(int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
